nabp_mapper_lut_sym: RTL and testbench

NABP_MAPPER_LUT_SYM -- requirements
Module: nabp_mapper_lut_sym

---
 rtl/nabp_mapper_pkg.sv | 18 +
 rtl/nabp_mapper_table.sv | 53 +++++
 rtl/nabp_mapper_lut_sym.sv | 140 ++++++++++++++
 tb/tb_nabp_mapper_lut_sym.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_mapper_pkg.sv
// Shared widths, angle count and generated initial coefficient tables
// for the NABP angle mapper.
package nabp_mapper_pkg;

  localparam int DEF_ANGLE_W    = 8;
  localparam int DEF_NUM_ANGLES = 180;
  localparam int DEF_PART_W     = 16;
  localparam int DEF_BASE_W     = 20;

  function automatic logic [DEF_PART_W-1:0] init_part(input int i);
    return DEF_PART_W'(i * 257);
  endfunction

  function automatic logic [DEF_BASE_W-1:0] init_base(input int i);
    return DEF_BASE_W'(i * 1031 - 32768);
  endfunction

endpackage

// File: rtl/nabp_mapper_table.sv
// 1-write/1-read synchronous coefficient RAM, preloaded with the
// package tables; a same-cycle read of a written entry sees old data.
module nabp_mapper_table
  import nabp_mapper_pkg::*;
#(
  parameter int DEPTH = DEF_NUM_ANGLES / 2 + 1,
  parameter int AW    = $clog2(DEPTH),
  parameter int PW    = DEF_PART_W,
  parameter int BW    = DEF_BASE_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [PW-1:0] wp,
  input  logic [BW-1:0] wb,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [PW-1:0] rp,
  output logic [BW-1:0] rb
);

  typedef logic [PW-1:0] pmem_t [DEPTH];
  typedef logic [BW-1:0] bmem_t [DEPTH];

  function automatic pmem_t gen_p();
    pmem_t m;
    for (int i = 0; i < DEPTH; i++)
      m[i] = PW'(init_part(i));
    return m;
  endfunction

  function automatic bmem_t gen_b();
    bmem_t m;
    for (int i = 0; i < DEPTH; i++)
      m[i] = BW'(init_base(i));
    return m;
  endfunction

  pmem_t mem_p = gen_p();
  bmem_t mem_b = gen_b();

  always_ff @(posedge clk) begin
    if (we) begin
      mem_p[wa] <= wp;
      mem_b[wa] <= wb;
    end
    if (re) begin
      rp <= mem_p[ra];
      rb <= mem_b[ra];
    end
  end

endmodule

// File: rtl/nabp_mapper_lut_sym.sv
// Angle -> (accu_part, accu_base) lookup, two register stages, with an
// optional half-turn symmetry fold that negates the base on the far half.
module nabp_mapper_lut_sym
  import nabp_mapper_pkg::*;
#(
  parameter int ANGLE_W    = DEF_ANGLE_W,
  parameter int NUM_ANGLES = DEF_NUM_ANGLES,
  parameter int PART_W     = DEF_PART_W,
  parameter int BASE_W     = DEF_BASE_W,
  parameter int MIRROR     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] in_angle,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ANGLE_W-1:0] out_angle,
  output logic [PART_W-1:0]  out_accu_part,
  output logic [BASE_W-1:0]  out_accu_base,
  output logic               out_err,
  input  logic               wr_en,
  input  logic [ANGLE_W-1:0] wr_addr,
  input  logic [PART_W-1:0]  wr_part,
  input  logic [BASE_W-1:0]  wr_base
);

  localparam int HALF  = NUM_ANGLES / 2;
  localparam int DEPTH = (MIRROR != 0) ? HALF + 1 : NUM_ANGLES;
  localparam int TW    = $clog2(DEPTH);

  localparam logic [BASE_W-1:0] BMIN =
    {1'b1, {(BASE_W-1){1'b0}}};
  localparam logic [BASE_W-1:0] BMAX =
    {1'b0, {(BASE_W-1){1'b1}}};

  logic               en1;
  logic               en2;
  logic               s1_valid;
  logic               s1_err;
  logic               s1_neg;
  logic [ANGLE_W-1:0] s1_angle;

  int                 ai;
  logic               f_err;
  logic               f_neg;
  logic               rd_en;
  logic [TW-1:0]      rd_addr;
  logic               wr_ok;
  logic [PART_W-1:0]  rd_part;
  logic [BASE_W-1:0]  rd_base;
  logic [PART_W-1:0]  m_part;
  logic [BASE_W-1:0]  m_base;

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;
  assign wr_ok    = wr_en && (int'(wr_addr) < DEPTH);

  always_comb begin
    ai      = int'(in_angle);
    f_err   = ai >= NUM_ANGLES;
    f_neg   = 1'b0;
    rd_addr = TW'(ai);
    if (MIRROR != 0 && ai > HALF) begin
      f_neg   = 1'b1;
      rd_addr = TW'(NUM_ANGLES - ai);
    end
    rd_en = en1 && in_valid && !f_err;
  end

  nabp_mapper_table #(
    .DEPTH (DEPTH),
    .AW    (TW),
    .PW    (PART_W),
    .BW    (BASE_W)
  ) u_table (
    .clk (clk),
    .we  (wr_ok),
    .wa  (TW'(wr_addr)),
    .wp  (wr_part),
    .wb  (wr_base),
    .re  (rd_en),
    .ra  (rd_addr),
    .rp  (rd_part),
    .rb  (rd_base)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_neg   <= 1'b0;
      s1_angle <= '0;
    end else if (en1) begin
      s1_valid <= in_valid;
      s1_err   <= f_err;
      s1_neg   <= f_neg;
      s1_angle <= in_angle;
    end
  end

  // the single unrepresentable negation clamps to the positive limit
  always_comb begin
    m_part = rd_part;
    m_base = rd_base;
    unique case (1'b1)
      s1_err: begin
        m_part = '0;
        m_base = '0;
      end
      !s1_err && !s1_neg: ;
      !s1_err && s1_neg && rd_base == BMIN:
        m_base = BMAX;
      !s1_err && s1_neg && rd_base != BMIN:
        m_base = '0 - rd_base;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_err       <= 1'b0;
      out_angle     <= '0;
      out_accu_part <= '0;
      out_accu_base <= '0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_err       <= s1_err;
        out_angle     <= s1_angle;
        out_accu_part <= m_part;
        out_accu_base <= m_base;
      end
    end
  end

endmodule

// File: tb/tb_nabp_mapper_lut_sym.sv
// Randomised and directed bench for nabp_mapper_lut_sym against a
// table/queue reference model of the fold, saturation and handshake.
module tb_nabp_mapper_lut_sym;
  import nabp_mapper_pkg::*;

  localparam int AW = 8;
  localparam int N  = 180;
  localparam int PW = 16;
  localparam int BW = 20;
  localparam int H  = N / 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_angle = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_angle;
  logic [PW-1:0] out_accu_part;
  logic [BW-1:0] out_accu_base;
  logic          out_err;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_part = '0;
  logic [BW-1:0] wr_base = '0;

  always #5 clk = ~clk;

  nabp_mapper_lut_sym dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_angle      (in_angle),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_angle     (out_angle),
    .out_accu_part (out_accu_part),
    .out_accu_base (out_accu_base),
    .out_err       (out_err),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_part       (wr_part),
    .wr_base       (wr_base)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] p;
    logic [BW-1:0] b;
    logic          e;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [PW-1:0] mp [H+1];
  logic [BW-1:0] mb [H+1];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  bit            chk = 1'b0;
  bit            lat = 1'b0;
  bit            stalled = 1'b0;
  bit            acc = 1'b0;
  logic [63:0]   held = '0;

  function automatic exp_t model(input int a);
    exp_t r;
    int   v;
    r.a = AW'(a);
    r.e = 1'b0;
    r.p = '0;
    r.b = '0;
    r.cyc = 0;
    if (a >= N) begin
      r.e = 1'b1;
    end else if (a <= H) begin
      r.p = mp[a];
      r.b = mb[a];
    end else begin
      r.p = mp[N-a];
      v = $signed(mb[N-a]);
      v = -v;
      if (v > 2**(BW-1) - 1) v = 2**(BW-1) - 1;
      r.b = BW'(v);
    end
    return r;
  endfunction

  task automatic chk1(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    exp_t e;
    exp_t w;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (chk) begin
      if (stalled)
        chk1("hold", {18'd0, out_valid, out_angle, out_err,
                      out_accu_part, out_accu_base}, held);
      chk1("in_ready", 64'(in_ready),
           64'(!(q.size() == 2 && !out_ready)));
      if (out_valid) begin
        chk1("no_spurious", 64'(q.size() != 0), 64'd1);
        if (out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk1("tag", 64'(out_angle), 64'(e.a));
          chk1("err", 64'(out_err), 64'(e.e));
          chk1("part", 64'(out_accu_part), 64'(e.p));
          chk1("base", 64'(out_accu_base), 64'(e.b));
          if (lat) chk1("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      stalled = out_valid && !out_ready;
      held = {18'd0, out_valid, out_angle, out_err,
              out_accu_part, out_accu_base};
    end
    if (acc) begin
      w = model(int'(in_angle));
      w.cyc = cyc;
      q.push_back(w);
    end
    if (wr_en && int'(wr_addr) <= H) begin
      mp[int'(wr_addr)] = wr_part;
      mb[int'(wr_addr)] = wr_base;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    in_valid = 1'b0;
    wr_en = 1'b0;
    chk = 1'b0;
    repeat (n) tick();
    q.delete();
    stalled = 1'b0;
    chk1("rst_valid", 64'(out_valid), 64'd0);
    chk1("rst_err", 64'(out_err), 64'd0);
    chk1("rst_angle", 64'(out_angle), 64'd0);
    chk1("rst_part", 64'(out_accu_part), 64'd0);
    chk1("rst_base", 64'(out_accu_base), 64'd0);
    reset_n = 1'b1;
    chk = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    wr_en = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk1("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic req(input int a);
    in_valid = 1'b1;
    in_angle = AW'(a);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int p, input int b);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_part = PW'(p);
    wr_base = BW'(b);
  endtask

  initial begin
    int i;
    int n;
    for (int k = 0; k <= H; k++) begin
      mp[k] = init_part(k);
      mb[k] = init_base(k);
    end

    do_reset(3);
    out_ready = 1'b1;
    lat = 1'b1;
    tick();

    req(5);
    req(175);
    req(H);
    drain();

    wr(30, 'h1234, 'h00100);
    tick();
    wr_en = 1'b0;
    req(30);
    req(150);
    drain();

    req(90);
    req(200);
    req(255);
    req(N);
    drain();

    wr(10, 'h0abc, 'h80000);
    tick();
    wr_en = 1'b0;
    req(170);
    req(10);
    drain();

    wr(45, 'h5555, 'h12345);
    in_valid = 1'b1;
    in_angle = AW'(45);
    tick();
    wr_en = 1'b0;
    req(45);
    req(135);
    drain();

    wr(H + 1, 'hdead, 'h0beef);
    tick();
    wr_en = 1'b0;
    req(H - 1);
    drain();

    lat = 1'b0;
    i = 0;
    n = 0;
    while (i < N && n < 2000) begin
      in_valid = 1'b1;
      in_angle = AW'(i);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      tick();
      if (acc) i++;
      n++;
    end
    chk1("sweep_done", 64'(i), 64'(N));
    drain();

    out_ready = 1'b0;
    req(20);
    req(21);
    do_reset(2);
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      chk1("flush_valid", 64'(out_valid), 64'd0);
    end

    repeat (800) begin
      in_valid = 1'($urandom_range(0, 1));
      in_angle = AW'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      wr_en = ($urandom_range(0, 7) == 0);
      wr_addr = AW'($urandom_range(0, 100));
      wr_part = PW'($urandom);
      wr_base = BW'($urandom);
      tick();
    end
    drain();

    req(0);
    req(N - 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
